// File: rtl/wb_rr_arbiter_pkg.sv
// Shared Wishbone definitions: arbiter state encodings, default bus widths
// and a helper that sizes master index fields.
package wb_rr_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;
  localparam int WB_TAG_W = 4;

  // Width of an index able to address n masters (at least one bit).
  function automatic int pick_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_pick.sv
// Combinational round-robin picker: returns the first requester found when
// searching last+1, last+2, ... modulo NUM_M, plus a valid flag.
module wb_rr_pick
  import wb_rr_arbiter_pkg::*;
#(
  parameter int NUM_M = 2,
  parameter int IDX_W = pick_idx_w(NUM_M)
) (
  input  logic [NUM_M-1:0] i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [IDX_W-1:0] o_gnt,
  output logic             o_vld
);

  int               w_idx;
  logic [IDX_W-1:0] w_cand;

  // Walk the ring from the farthest candidate back to the nearest so the
  // nearest requester after i_last is the one left standing.
  always_comb begin
    o_gnt  = '0;
    o_vld  = 1'b0;
    w_idx  = 0;
    w_cand = '0;
    for (int k = NUM_M; k >= 1; k--) begin
      w_idx  = (int'(i_last) + k) % NUM_M;
      w_cand = IDX_W'(w_idx);
      if (i_req[w_cand]) begin
        o_gnt = w_cand;
        o_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Wishbone classic-cycle arbiter sharing one slave between NUM_M masters.
// Round-robin grant per CYC tenure, combinational slave-side mux, response
// routing to the granted master only, and a watchdog that aborts transfers
// the slave never terminates.
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int NUM_M   = 2,
  parameter int ADR_W   = WB_ADR_W,
  parameter int DAT_W   = WB_DAT_W,
  parameter int SEL_W   = WB_SEL_W,
  parameter int TAG_W   = WB_TAG_W,
  parameter int TIMEOUT = 255
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  input  logic [NUM_M-1:0]       M_CYC_I,
  input  logic [NUM_M-1:0]       M_STB_I,
  input  logic [NUM_M-1:0]       M_WE_I,
  input  logic [NUM_M*ADR_W-1:0] M_ADR_I,
  input  logic [NUM_M*DAT_W-1:0] M_DAT_I,
  input  logic [NUM_M*SEL_W-1:0] M_SEL_I,
  input  logic [NUM_M*TAG_W-1:0] M_TAG_I,
  output logic [DAT_W-1:0]       M_DAT_O,
  output logic [TAG_W-1:0]       M_TAG_O,
  output logic [NUM_M-1:0]       M_ACK_O,
  output logic [NUM_M-1:0]       M_RTY_O,
  output logic [NUM_M-1:0]       M_ERR_O,
  output logic                   S_CYC_O,
  output logic                   S_STB_O,
  output logic                   S_WE_O,
  output logic [ADR_W-1:0]       S_ADR_O,
  output logic [DAT_W-1:0]       S_DAT_O,
  output logic [SEL_W-1:0]       S_SEL_O,
  output logic [TAG_W-1:0]       S_TAG_O,
  input  logic [DAT_W-1:0]       S_DAT_I,
  input  logic [TAG_W-1:0]       S_TAG_I,
  input  logic                   S_ACK_I,
  input  logic                   S_RTY_I,
  input  logic                   S_ERR_I
);

  localparam int IDX_W  = pick_idx_w(NUM_M);
  localparam int WDOG_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_gnt;
  logic [IDX_W-1:0] r_last;
  logic [WDOG_W-1:0] r_wdog;

  logic [IDX_W-1:0] w_pick_gnt;
  logic             w_pick_vld;
  logic             w_gnt_cyc;
  logic             w_act;
  logic             w_term;
  logic             w_wd_hit;
  logic             w_timeout;

  wb_rr_pick #(
    .NUM_M (NUM_M),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req  (M_CYC_I),
    .i_last (r_last),
    .o_gnt  (w_pick_gnt),
    .o_vld  (w_pick_vld)
  );

  assign M_DAT_O = S_DAT_I;
  assign M_TAG_O = S_TAG_I;
  assign w_term  = S_ACK_I | S_RTY_I | S_ERR_I;

  generate
    if (TIMEOUT > 0) begin : g_wdog
      assign w_wd_hit = (r_wdog == WDOG_W'(TIMEOUT - 1));
    end else begin : g_no_wdog
      assign w_wd_hit = 1'b0;
    end
  endgenerate

  // Slave-side mux: the granted master drives the slave only while it holds
  // CYC in GRANT, so IDLE, ABORT and the release cycle all present zeros.
  always_comb begin
    w_gnt_cyc = 1'b0;
    S_STB_O   = 1'b0;
    S_WE_O    = 1'b0;
    S_ADR_O   = '0;
    S_DAT_O   = '0;
    S_SEL_O   = '0;
    S_TAG_O   = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (r_gnt == IDX_W'(i)) begin
        w_gnt_cyc = M_CYC_I[i];
        S_STB_O   = M_STB_I[i];
        S_WE_O    = M_WE_I[i];
        S_ADR_O   = M_ADR_I[i*ADR_W +: ADR_W];
        S_DAT_O   = M_DAT_I[i*DAT_W +: DAT_W];
        S_SEL_O   = M_SEL_I[i*SEL_W +: SEL_W];
        S_TAG_O   = M_TAG_I[i*TAG_W +: TAG_W];
      end
    end
    w_act   = (r_state == ST_GRANT) && w_gnt_cyc;
    S_CYC_O = w_act;
    S_STB_O = S_STB_O & w_act;
    S_WE_O  = S_WE_O & w_act;
    if (!w_act) begin
      S_ADR_O = '0;
      S_DAT_O = '0;
      S_SEL_O = '0;
      S_TAG_O = '0;
    end
  end

  // A termination in the same cycle as the last watchdog count wins.
  assign w_timeout = S_STB_O & ~w_term & w_wd_hit;

  // Route terminations to the granted master; the watchdog abort shows up
  // as a one-cycle ERR to that master.
  always_comb begin
    M_ACK_O = '0;
    M_RTY_O = '0;
    M_ERR_O = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (S_STB_O && (r_gnt == IDX_W'(i))) begin
        M_ACK_O[i] = S_ACK_I;
        M_RTY_O[i] = S_RTY_I;
        M_ERR_O[i] = S_ERR_I | w_timeout;
      end
    end
  end

  // Tenure FSM: arbitrate in IDLE, hold the grant for the whole CYC tenure,
  // sit in ABORT after a watchdog expiry until the master lets go.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_last  <= IDX_W'(NUM_M - 1);
      r_wdog  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_wdog <= '0;
          if (w_pick_vld) begin
            r_gnt   <= w_pick_gnt;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!w_gnt_cyc) begin
            r_last  <= r_gnt;
            r_wdog  <= '0;
            r_state <= ST_IDLE;
          end else if (w_timeout) begin
            r_wdog  <= '0;
            r_state <= ST_ABORT;
          end else if (S_STB_O && !w_term) begin
            if (r_wdog != '1) r_wdog <= r_wdog + 1'b1;
          end else begin
            r_wdog <= '0;
          end
        end
        ST_ABORT: begin
          r_wdog <= '0;
          if (!w_gnt_cyc) begin
            r_last  <= r_gnt;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_wdog  <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed scenarios followed by
// randomized traffic, all compared against a tenure-level reference model.
module tb_wb_rr_arbiter;

  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TW = 4;
  localparam int TO = 8;

  logic CLK_I = 1'b0;
  logic RST_I;
  logic [NM-1:0]    cyc, stb, we;
  logic [NM*AW-1:0] adr;
  logic [NM*DW-1:0] dat;
  logic [NM*SW-1:0] sel;
  logic [NM*TW-1:0] tag;
  logic [DW-1:0] M_DAT_O, S_DAT_O, s_dat;
  logic [TW-1:0] M_TAG_O, S_TAG_O, s_tag;
  logic [NM-1:0] M_ACK_O, M_RTY_O, M_ERR_O;
  logic S_CYC_O, S_STB_O, S_WE_O;
  logic [AW-1:0] S_ADR_O;
  logic [SW-1:0] S_SEL_O;
  logic s_ack, s_rty, s_err;

  wb_rr_arbiter #(
    .NUM_M(NM), .ADR_W(AW), .DAT_W(DW), .SEL_W(SW), .TAG_W(TW), .TIMEOUT(TO)
  ) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .M_CYC_I(cyc), .M_STB_I(stb), .M_WE_I(we),
    .M_ADR_I(adr), .M_DAT_I(dat), .M_SEL_I(sel), .M_TAG_I(tag),
    .M_DAT_O(M_DAT_O), .M_TAG_O(M_TAG_O),
    .M_ACK_O(M_ACK_O), .M_RTY_O(M_RTY_O), .M_ERR_O(M_ERR_O),
    .S_CYC_O(S_CYC_O), .S_STB_O(S_STB_O), .S_WE_O(S_WE_O),
    .S_ADR_O(S_ADR_O), .S_DAT_O(S_DAT_O), .S_SEL_O(S_SEL_O), .S_TAG_O(S_TAG_O),
    .S_DAT_I(s_dat), .S_TAG_I(s_tag),
    .S_ACK_I(s_ack), .S_RTY_I(s_rty), .S_ERR_I(s_err)
  );

  always #5 CLK_I = ~CLK_I;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tg, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tg, got, exp);
    end
  endtask

  // Reference model: who owns the slave (-1 = nobody), whether that tenure
  // was aborted, who owned it last, and how long the current STB has waited.
  int m_owner, m_last, m_wd;
  bit m_abort;
  logic e_cyc, e_stb, e_we, e_to;
  logic [AW-1:0] e_adr;
  logic [DW-1:0] e_dat;
  logic [SW-1:0] e_sel;
  logic [TW-1:0] e_tag;
  logic [NM-1:0] e_ack, e_rty, e_err;

  task automatic model_reset();
    m_owner = -1;
    m_last  = NM - 1;
    m_wd    = 0;
    m_abort = 0;
  endtask

  task automatic model_eval();
    int o;
    bit act, term;
    o     = (m_owner < 0) ? 0 : m_owner;
    act   = (m_owner >= 0) && !m_abort && cyc[o];
    e_cyc = act;
    e_stb = act && stb[o];
    e_we  = act && we[o];
    e_adr = act ? adr[o*AW +: AW] : '0;
    e_dat = act ? dat[o*DW +: DW] : '0;
    e_sel = act ? sel[o*SW +: SW] : '0;
    e_tag = act ? tag[o*TW +: TW] : '0;
    term  = s_ack || s_rty || s_err;
    e_to  = e_stb && !term && (m_wd == TO - 1);
    e_ack = '0;
    e_rty = '0;
    e_err = '0;
    if (e_stb) begin
      e_ack[o] = s_ack;
      e_rty[o] = s_rty;
      e_err[o] = s_err | e_to;
    end
  endtask

  task automatic model_clock();
    if (RST_I) model_reset();
    else if (m_owner < 0) begin
      for (int k = 1; k <= NM; k++) begin
        if (cyc[(m_last + k) % NM]) begin
          m_owner = (m_last + k) % NM;
          break;
        end
      end
      m_abort = 0;
      m_wd    = 0;
    end else if (!cyc[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
      m_abort = 0;
      m_wd    = 0;
    end else if (!m_abort) begin
      if (e_to) begin
        m_abort = 1;
        m_wd    = 0;
      end else if (e_stb && !(s_ack || s_rty || s_err)) m_wd++;
      else m_wd = 0;
    end
  endtask

  // One clock: compare all outputs mid-cycle, then advance the model.
  task automatic step();
    @(negedge CLK_I);
    model_eval();
    chk("s_ctrl", {S_CYC_O, S_STB_O, S_WE_O}, {e_cyc, e_stb, e_we});
    chk("s_bus", {S_ADR_O, S_DAT_O, S_SEL_O, S_TAG_O}, {e_adr, e_dat, e_sel, e_tag});
    chk("m_resp", {M_ACK_O, M_RTY_O, M_ERR_O}, {e_ack, e_rty, e_err});
    chk("m_pass", {M_DAT_O, M_TAG_O}, {s_dat, s_tag});
    @(posedge CLK_I);
    model_clock();
    #1;
  endtask

  logic [NM-1:0] drop;
  int            order[$];
  int            guard;
  logic [23:0]   ord_pk;
  bit            quiet;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    cyc = '0; stb = '0; we = '0; adr = '0; dat = '0; sel = '0; tag = '0;
    s_dat = '0; s_tag = '0; s_ack = 0; s_rty = 0; s_err = 0;
    RST_I = 1; model_reset();
    cyc = 3'b011; stb = 3'b011;
    step(); step();
    chk("rst_idle", {S_CYC_O, S_STB_O, M_ACK_O, M_ERR_O}, 0);
    RST_I = 0; cyc = '0; stb = '0;
    step();

    // Single master write with two wait states
    cyc = 3'b001; stb = 3'b001; we = 3'b001;
    adr[0 +: AW] = 32'h4; dat[0 +: DW] = 32'hDEADBEEF; sel[0 +: SW] = 4'hF; tag[0 +: TW] = 4'h3;
    #1 chk("t2_arb_lat", S_CYC_O, 0);
    step();
    chk("t2_adr", S_ADR_O, 32'h4);
    chk("t2_dat", S_DAT_O, 32'hDEADBEEF);
    chk("t2_sel", S_SEL_O, 4'hF);
    step(); step();
    s_ack = 1;
    #1 chk("t2_ack", M_ACK_O, 3'b001);
    step();
    s_ack = 0; cyc = '0; stb = '0;
    #1 chk("t2_drop", S_CYC_O, 0);
    step(); step();

    // Asynchronous reset in the middle of a transfer
    cyc = 3'b001; stb = 3'b001; we = 3'b001; adr[0 +: AW] = 32'h10;
    step(); step();
    chk("t1_pre", S_CYC_O, 1);
    RST_I = 1; model_reset();
    cyc = 3'b011; stb = 3'b011; adr[AW +: AW] = 32'h200;
    #1 chk("t1_async", S_CYC_O, 0);
    step();
    RST_I = 0;
    step();
    chk("t1_regain", {S_CYC_O, S_ADR_O}, {1'b1, 32'h10});
    cyc = '0; stb = '0;
    step(); step();
    RST_I = 1; model_reset();
    step();
    RST_I = 0;

    // Contention: both masters request together, three tenures each
    drop = '0; order.delete(); guard = 0;
    adr[0 +: AW] = 32'h100; adr[AW +: AW] = 32'h200; we = '0;
    while (order.size() < 6 && guard < 60) begin
      cyc = 3'b011 & ~drop; stb = cyc;
      s_ack = 0;
      #1 s_ack = S_CYC_O;
      #1 drop = M_ACK_O;
      for (int i = 0; i < NM; i++) if (M_ACK_O[i]) order.push_back(i);
      step();
      guard++;
    end
    chk("t3_count", order.size(), 6);
    ord_pk = '0;
    for (int i = 0; i < order.size() && i < 6; i++) ord_pk = {ord_pk[19:0], 4'(order[i])};
    chk("t3_order", ord_pk, 24'h010101);
    cyc = '0; stb = '0; s_ack = 0;
    step(); step();

    // Block hold: M1 burst is not interrupted by M0
    cyc = 3'b010; stb = 3'b010; adr[AW +: AW] = 32'h20;
    step();
    cyc = 3'b011; stb = 3'b011; adr[0 +: AW] = 32'h300;
    for (int k = 0; k < 4; k++) begin
      adr[AW +: AW] = 32'h20 + 4 * k;
      s_ack = 1; s_dat = 32'h11 * (k + 1);
      #1 chk("t4_adr", S_ADR_O, 32'h20 + 4 * k);
      chk("t4_ack", M_ACK_O, 3'b010);
      chk("t4_dat", M_DAT_O, 32'h11 * (k + 1));
      step();
    end
    s_ack = 0; s_dat = '0; cyc = 3'b001; stb = 3'b001;
    step(); step();
    chk("t4_m0_after", {S_CYC_O, S_ADR_O}, {1'b1, 32'h300});
    cyc = '0; stb = '0;
    step(); step();

    // Watchdog abort on the 8th unterminated STB cycle
    cyc = 3'b001; stb = 3'b001; adr[0 +: AW] = 32'h40;
    step();
    for (int k = 1; k <= 8; k++) begin
      #1 chk("t5_err", M_ERR_O, (k == 8) ? 3'b001 : 3'b000);
      step();
    end
    cyc = 3'b011; stb = 3'b011; adr[AW +: AW] = 32'h500; s_ack = 1;
    #1 chk("t5_abort_cyc", S_CYC_O, 0);
    chk("t5_late_ack", M_ACK_O, 0);
    step(); step();
    s_ack = 0; cyc = 3'b010; stb = 3'b010;
    step(); step();
    chk("t5_m1", {S_CYC_O, S_ADR_O}, {1'b1, 32'h500});
    cyc = '0; stb = '0;
    step(); step();

    // Termination on the watchdog's last cycle wins
    cyc = 3'b001; stb = 3'b001; adr[0 +: AW] = 32'h60;
    step();
    for (int k = 1; k <= 8; k++) begin
      s_ack = (k == 8);
      #1 chk("t6_ack", M_ACK_O, (k == 8) ? 3'b001 : 3'b000);
      chk("t6_err", M_ERR_O, 0);
      step();
    end
    s_ack = 0;
    #1 chk("t6_noabort", S_CYC_O, 1);
    cyc = '0; stb = '0;
    step(); step();

    // Randomized traffic, alternating busy and sluggish slave phases
    for (int n = 0; n < 3000; n++) begin
      quiet = ((n / 500) % 2) == 1;
      if (RST_I) RST_I = 0;
      else if ($urandom_range(0, 599) == 0) begin
        RST_I = 1; model_reset();
      end
      for (int i = 0; i < NM; i++) begin
        if ($urandom_range(0, quiet ? 31 : 7) == 0) cyc[i] = ~cyc[i];
        stb[i] = cyc[i] ? (quiet || ($urandom_range(0, 9) < 7)) : 1'($urandom_range(0, 1));
        we[i] = 1'($urandom);
        adr[i*AW +: AW] = $urandom;
        dat[i*DW +: DW] = $urandom;
        sel[i*SW +: SW] = SW'($urandom);
        tag[i*TW +: TW] = TW'($urandom);
      end
      s_dat = $urandom; s_tag = TW'($urandom);
      if ($urandom_range(0, quiet ? 15 : 2) == 0) {s_ack, s_rty, s_err} = 3'($urandom_range(1, 7));
      else {s_ack, s_rty, s_err} = 3'b000;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
Synthesizable Wishbone classic-cycle arbiter that shares one slave port (e.g. the GPIO core) between NUM_M masters (testbench master, CPU, DMA).
- Grants the bus round-robin per CYC tenure and multiplexes address, data, select, tag and control onto the slave.
- Routes ACK/RTY/ERR and read data back to the granted master only.
- Watchdog aborts any transfer the slave never terminates.

Parameters:
NUM_M, 2, number of masters (2..8)
ADR_W, 32, address width
DAT_W, 32, data width
SEL_W, 4, byte-select width
TAG_W, 4, tag width
TIMEOUT, 255, cycles STB may wait for termination before abort; 0 disables watchdog

Ports:
CLK_I  in  1  clock, rising edge
RST_I  in  1  asynchronous, active-high reset
M_CYC_I  in  NUM_M  per-master CYC
M_STB_I  in  NUM_M  per-master STB
M_WE_I  in  NUM_M  per-master WE
M_ADR_I  in  NUM_M*ADR_W  master i at bits [i*ADR_W +: ADR_W]
M_DAT_I  in  NUM_M*DAT_W  write data, same packing
M_SEL_I  in  NUM_M*SEL_W  byte selects, same packing
M_TAG_I  in  NUM_M*TAG_W  tags, same packing
M_DAT_O  out  DAT_W  read data, broadcast to all masters
M_TAG_O  out  TAG_W  slave tag, broadcast to all masters
M_ACK_O  out  NUM_M  per-master ACK
M_RTY_O  out  NUM_M  per-master RTY
M_ERR_O  out  NUM_M  per-master ERR
S_CYC_O, S_STB_O, S_WE_O  out  1 each  slave control
S_ADR_O  out  ADR_W  slave address
S_DAT_O  out  DAT_W  slave write data
S_SEL_O  out  SEL_W  slave byte selects
S_TAG_O  out  TAG_W  slave tag
S_DAT_I  in  DAT_W  slave read data
S_TAG_I  in  TAG_W  slave tag
S_ACK_I, S_RTY_I, S_ERR_I  in  1 each  slave termination

Behaviour:
- Reset (async, RST_I high): state=IDLE, gnt=0, last=NUM_M-1 (master 0 wins first), wdog=0.
- Outputs during reset and IDLE: all S_* outputs 0; all M_ACK/RTY/ERR 0.
- M_DAT_O = S_DAT_I and M_TAG_O = S_TAG_I at all times (combinational pass-through).
- States: IDLE, GRANT, ABORT.
- IDLE:
  - If any M_CYC_I is high, gnt <= first requester searching last+1, last+2, ... modulo NUM_M; go to GRANT.
  - Arbitration latency is 1 cycle: slave sees CYC on the cycle after the request.
- GRANT:
  - S_CYC_O = M_CYC_I[gnt]; S_STB_O = M_STB_I[gnt]; WE/ADR/DAT/SEL/TAG muxed from gnt. All combinational, no added latency.
  - M_ACK_O[gnt] = S_ACK_I & S_STB_O; same rule for RTY and ERR. Non-granted masters see 0.
  - Grant held for the whole CYC tenure, so block transfers are never interleaved.
  - When M_CYC_I[gnt] is low: last <= gnt, go to IDLE. S_* are 0 that cycle, giving one dead cycle between tenures.
- Watchdog:
  - In GRANT, wdog increments each cycle S_STB_O=1 and no ACK/RTY/ERR is present.
  - wdog clears on any termination, or when STB is low.
  - When wdog==TIMEOUT-1 and still unterminated: assert M_ERR_O[gnt] for exactly that cycle, go to ABORT.
  - TIMEOUT=0 means never abort.
- ABORT:
  - S_CYC_O=S_STB_O=0; all master responses 0; late slave ACK/RTY/ERR ignored.
  - Stay until M_CYC_I[gnt]=0, then last <= gnt and go to IDLE.
- Simultaneous events:
  - Requests arriving in the same cycle are resolved purely by the round-robin pointer.
  - Slave termination in the same cycle as wdog==TIMEOUT-1: the termination wins, no abort.
- Masters dropping CYC mid-transfer while waiting: treated as release; the slave sees CYC fall.
- Widths: wdog is clog2(TIMEOUT+1) bits and saturates, never wraps.
- RTY is passed through only; the arbiter never retries on its own.

Decomposition:
- Shared package/include: state encodings (IDLE=2'd0, GRANT=2'd1, ABORT=2'd2) and the default bus widths (ADR_W, DAT_W, SEL_W, TAG_W) used by all Wishbone blocks.
- One sub-module: wb_rr_pick. Combinational round-robin priority picker; inputs req[NUM_M] and last, outputs gnt index and a valid flag.
- The slave-side mux and the watchdog stay in the top module.

Test Plan:
1. Reset mid-transfer: master 0 write to 0x10 in progress, assert RST_I -> S_CYC_O=0 immediately; after release master 0 regains the grant first.
2. Single master: M0 writes 0xDEADBEEF to 0x04, SEL=0xF; slave ACKs after 2 waits -> S_* mirror M0 from cycle after CYC; M_ACK_O=01 for one cycle; slave sees CYC drop next cycle.
3. Contention: M0 and M1 both raise CYC in the same cycle, 3 back-to-back tenures each -> grant order 0,1,0,1,0,1 with one idle cycle between tenures; M1 never sees ACK during M0 tenure.
4. Block hold: M1 runs a 4-beat read burst at 0x20..0x2C while M0 requests -> M0 is not granted until M1 drops CYC; read data 0x11,0x22,0x33,0x44 appears on M_DAT_O with M_ACK_O=10.
5. Timeout: TIMEOUT=8, slave never ACKs M0 read -> M_ERR_O[0] pulses on the 8th STB cycle; S_CYC_O is 0 next cycle; a late S_ACK_I is ignored; M1 is granted after M0 drops CYC.
6. Termination race: TIMEOUT=8, slave ACKs exactly on cycle 8 -> M_ACK_O[0]=1 and M_ERR_O=0.
